// File: rtl/arb_types.sv
// Shared types for the memory arbiter: burst geometry defaults, FSM states,
// requester identity and the line-alignment helper.
package arb_types;

    localparam int BEATS_DEF  = 4;
    localparam int BEAT_W_DEF = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_READ  = 3'd1,
        D_READ  = 3'd2,
        D_WRITE = 3'd3,
        DONE    = 3'd4
    } arb_state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_e;

    // Clear the byte-offset-within-line bits of an address.
    function automatic logic [31:0] line_align(input logic [31:0] addr, input int line_bytes);
        return addr & ~(32'(line_bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Beat counter plus full-line assembly register for burst transfers.
// The counter is usable on its own (write bursts) by leaving store low.
module line_buffer
    import arb_types::*;
#(
    parameter int BEATS  = BEATS_DEF,
    parameter int BEAT_W = BEAT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       adv,
    input  logic                       store,
    input  logic [BEAT_W-1:0]          beat_in,
    output logic [$clog2(BEATS)-1:0]   cnt,
    output logic                       last,
    output logic [BEATS*BEAT_W-1:0]    line
);

    localparam int CNT_W  = $clog2(BEATS);
    localparam int LINE_W = BEATS * BEAT_W;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;

    // Drop the incoming beat into its slot and step the beat index.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (store) begin
            line_d[BEAT_W*cnt_q +: BEAT_W] = beat_in;
        end
        if (clr) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and line register; reset also discards any partial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(BEATS - 1));
    assign line = line_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I-side, D-side) arbiter onto a single burst memory port.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | sample requests, pick a side, latch aligned address
// I_READ  | burst read on behalf of the I-side
// D_READ  | burst read on behalf of the D-side
// D_WRITE | burst write of d_wdata, one beat per pmem_resp
// DONE    | one-cycle resp pulse to the granted side, flip priority
module mem_arbiter
    import arb_types::*;
#(
    parameter int BEATS  = BEATS_DEF,
    parameter int BEAT_W = BEAT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_read,
    input  logic [31:0]             i_address,
    output logic [BEATS*BEAT_W-1:0] i_rdata,
    output logic                    i_resp,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [31:0]             d_address,
    input  logic [BEATS*BEAT_W-1:0] d_wdata,
    output logic [BEATS*BEAT_W-1:0] d_rdata,
    output logic                    d_resp,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [31:0]             pmem_address,
    output logic [BEAT_W-1:0]       pmem_wdata,
    input  logic                    pmem_resp,
    input  logic [BEAT_W-1:0]       pmem_rdata
);

    localparam int CNT_W      = $clog2(BEATS);
    localparam int LINE_W     = BEATS * BEAT_W;
    localparam int LINE_BYTES = LINE_W / 8;

    arb_state_e  state_q, state_d;
    arb_side_e   gnt_q, gnt_d;
    arb_side_e   last_q, last_d;    // side served most recently; the other wins a tie
    arb_side_e   pick;
    logic [31:0] addr_q, addr_d;

    logic              d_pend;
    logic              in_burst;
    logic              in_read;
    logic              clr, adv, store;
    logic [CNT_W-1:0]  cnt;
    logic              last_beat;
    logic [LINE_W-1:0] line;

    assign d_pend   = d_read | d_write;
    assign in_read  = (state_q == I_READ) || (state_q == D_READ);
    assign in_burst = in_read || (state_q == D_WRITE);
    assign adv      = pmem_resp && in_burst;
    assign store    = pmem_resp && in_read;

    line_buffer #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .adv     (adv),
        .store   (store),
        .beat_in (pmem_rdata),
        .cnt     (cnt),
        .last    (last_beat),
        .line    (line)
    );

    // Arbitration and burst sequencing.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        clr     = 1'b0;
        pick    = SIDE_I;
        unique case (state_q)
            IDLE: begin
                if (i_read && d_pend) begin
                    pick = (last_q == SIDE_D) ? SIDE_I : SIDE_D;
                end else if (d_pend) begin
                    pick = SIDE_D;
                end
                if (i_read || d_pend) begin
                    clr   = 1'b1;
                    gnt_d = pick;
                    if (pick == SIDE_D) begin
                        addr_d  = line_align(d_address, LINE_BYTES);
                        // read+write together is treated as a write
                        state_d = d_write ? D_WRITE : D_READ;
                    end else begin
                        addr_d  = line_align(i_address, LINE_BYTES);
                        state_d = I_READ;
                    end
                end
            end
            I_READ, D_READ, D_WRITE: begin
                if (pmem_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, grant, priority and address registers. Priority resets as if
    // the I-side was served last, so the D-side wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= SIDE_I;
            last_q  <= SIDE_I;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

    // Current write beat, zero outside write bursts.
    always_comb begin
        pmem_wdata = '0;
        if (state_q == D_WRITE) begin
            pmem_wdata = d_wdata[BEAT_W*cnt +: BEAT_W];
        end
    end

    assign pmem_read    = in_read;
    assign pmem_write   = (state_q == D_WRITE);
    assign pmem_address = addr_q;
    assign i_resp       = (state_q == DONE) && (gnt_q == SIDE_I);
    assign d_resp       = (state_q == DONE) && (gnt_q == SIDE_D);
    assign i_rdata      = line;
    assign d_rdata      = line;

endmodule
